// File: rtl/regwr_arbiter_if.sv
// Bundle between the four register-file writers and the write-port arbiter.
// Handshake: a requester holds req/addr/data stable until it sees its ack bit high for one cycle; that cycle is the accepted write.
interface regwr_arbiter_if #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 5
);
    logic [3:0]        req;
    logic [3:0]        lock;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
    logic [ADDR_W-1:0] addr3;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic [DATA_W-1:0] data3;
    logic [3:0]        ack;
    logic [1:0]        sel;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;

    modport master (
        output req, lock, addr0, addr1, addr2, addr3, data0, data1, data2, data3,
        input  ack, sel, wr_en, wr_addr, wr_data, busy
    );

    modport slave (
        input  req, lock, addr0, addr1, addr2, addr3, data0, data1, data2, data3,
        output ack, sel, wr_en, wr_addr, wr_data, busy
    );
endinterface

// File: rtl/regwr_arbiter.sv
// Round-robin arbiter for the single register-file write port, with an
// optional lock that lets the owner issue back-to-back writes.
module regwr_arbiter #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    regwr_arbiter_if.slave  bus,
    output logic [0:0]      dbg_state
);
    localparam logic [0:0] ARB    = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]        state;
    logic [1:0]        ptr;
    logic [ADDR_W-1:0] addr_a [4];
    logic [DATA_W-1:0] data_a [4];
    logic [3:0]        eligible;
    logic [1:0]        cand;
    logic [1:0]        winner;
    logic              found;

    assign addr_a[0] = bus.addr0;
    assign addr_a[1] = bus.addr1;
    assign addr_a[2] = bus.addr2;
    assign addr_a[3] = bus.addr3;
    assign data_a[0] = bus.data0;
    assign data_a[1] = bus.data1;
    assign data_a[2] = bus.data2;
    assign data_a[3] = bus.data3;

    assign dbg_state = state;

    // The requester acked this cycle is masked so the others get the next slot.
    always_comb begin
        eligible = bus.req & ~bus.ack;
        found    = 1'b0;
        winner   = ptr;
        cand     = '0;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr + 2'(i);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ARB;
            ptr         <= 2'd3;
            bus.ack     <= '0;
            bus.sel     <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            bus.busy    <= 1'b0;
        end else begin
            case (state)
                ARB: begin
                    if (found) begin
                        bus.sel     <= winner;
                        bus.ack     <= 4'b0001 << winner;
                        bus.wr_addr <= addr_a[winner];
                        bus.wr_data <= data_a[winner];
                        // Register 0 is hardwired zero: acknowledge but do not write.
                        bus.wr_en   <= (addr_a[winner] != '0);
                        ptr         <= winner;
                        bus.busy    <= bus.lock[winner];
                        state       <= bus.lock[winner] ? LOCKED : ARB;
                    end else begin
                        bus.ack   <= '0;
                        bus.wr_en <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (bus.req[bus.sel] && bus.lock[bus.sel]) begin
                        bus.ack     <= 4'b0001 << bus.sel;
                        bus.wr_addr <= addr_a[bus.sel];
                        bus.wr_data <= data_a[bus.sel];
                        bus.wr_en   <= (addr_a[bus.sel] != '0);
                    end else begin
                        bus.ack   <= '0;
                        bus.wr_en <= 1'b0;
                        bus.busy  <= 1'b0;
                        state     <= ARB;
                    end
                end
                default: begin
                    bus.ack   <= '0;
                    bus.wr_en <= 1'b0;
                    bus.busy  <= 1'b0;
                    state     <= ARB;
                end
            endcase
        end
    end
endmodule
